// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter: grants whole cyc-framed cycles, one cycle arbitration latency.
// Losers wait without stalling the winner; a watchdog aborts stb-without-ack with a one-cycle err.
module wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  input  logic                                s_ack_i,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]              grant_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    BUSY     = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  logic [0:0]             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]          gidx_q;
  logic [IW-1:0]          ptr_q;
  logic [CW-1:0]          wd_cnt_q;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          k_idx;
  logic                   pick_vld;
  logic                   busy;
  logic                   cyc_g;
  logic                   stb_g;
  logic                   stalled;
  logic                   wd_fire;

  // Scan from the farthest offset down so the requester nearest the pointer wins.
  always_comb begin
    int k;
    k        = 0;
    k_idx    = '0;
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      k_idx = IW'(k);
      if (m_cyc_i[k_idx]) begin
        pick     = k_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign busy    = (state_q == BUSY);
  assign cyc_g   = busy & m_cyc_i[gidx_q];
  assign stb_g   = cyc_g & m_stb_i[gidx_q];
  assign stalled = stb_g & ~s_ack_i;
  // An ack on the final stalled cycle is not a stall, so ack beats the abort.
  assign wd_fire = (TIMEOUT_CYCLES > 0) && stalled && (wd_cnt_q == CNT_LAST);

  assign s_cyc_o = cyc_g;
  assign s_stb_o = stb_g & ~wd_fire;
  assign s_we_o  = busy & m_we_i[gidx_q];
  assign s_adr_o = busy ? m_adr_i[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_dat_o = busy ? m_dat_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign s_sel_o = busy ? m_sel_i[int'(gidx_q)*SW +: SW] : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) begin
      m_ack_o[gidx_q] = s_ack_i & m_stb_i[gidx_q];
      m_err_o[gidx_q] = wd_fire;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      wd_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q  <= BUSY;
            grant_q  <= NUM_MASTERS'(1) << pick;
            gidx_q   <= pick;
            wd_cnt_q <= '0;
          end
        end
        default: begin
          if (!cyc_g) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
            wd_cnt_q <= '0;
          end else if (stalled && !wd_fire) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end else begin
            wd_cnt_q <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Round-robin arbiter that shares one Wishbone classic slave port, such as an LED output peripheral, between NUM_MASTERS requesters, such as debug button pollers and a host/debug master. It grants whole bus cycles (cyc-framed) and muxes the winner's signals to the slave. It routes ack and error back to the winner only, and aborts a stalled access after a watchdog timeout so a dead slave cannot lock the bus. It sits between the masters and the slave in the top-level debug design.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width (multiple of 8)
TIMEOUT_CYCLES, 255, stb-without-ack cycles before abort; 0 disables watchdog

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_i  in  1  reset, asynchronous, active-low
m_cyc_i  in  NUM_MASTERS  per-master cycle request
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  packed byte selects
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master error (timeout abort)
m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_sel_o  out  DATA_WIDTH/8  slave byte selects
s_ack_i  in  1  slave ack
s_dat_i  in  DATA_WIDTH  slave read data
grant_o  out  NUM_MASTERS  registered one-hot grant (all zero when idle)

Behaviour:
- Reset (rst_i low, async): state IDLE, grant_o=0, priority pointer=0, timeout counter=0, m_err_o=0. With no grant, all s_* outputs and m_ack_o are 0.
- States: IDLE, BUSY.
- IDLE: if any m_cyc_i is high, select the first requester at or after the pointer, in modulo-NUM_MASTERS order. Register grant_o one-hot and go to BUSY. Arbitration latency is one cycle: cyc seen at edge N, slave sees s_cyc_o from edge N+1.
- BUSY: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o combinationally mux from the granted master.
  - m_ack_o[g] = s_ack_i & m_stb_i[g]. Other acks are 0.
  - m_dat_o = s_dat_i unconditionally.
- Grant is held while m_cyc_i[g] stays high. Block transfers (multiple stb/ack) are not interrupted.
- When m_cyc_i[g] goes low: s_cyc_o drops combinationally the same cycle, and the next edge returns to IDLE. The pointer becomes g+1 mod NUM_MASTERS. At least one idle cycle separates grants.
- Watchdog, when TIMEOUT_CYCLES>0:
  - The counter increments each BUSY cycle with s_stb_o high and s_ack_i low.
  - It clears on ack, on stb low, and on entering BUSY.
  - When the counter reaches TIMEOUT_CYCLES: m_err_o[g] pulses high for exactly one cycle, s_stb_o is forced low that cycle, and the counter clears. The grant is still released only on cyc drop.
- Simultaneous ack and timeout on the same cycle: ack wins, err is suppressed.
- Requests arriving while BUSY are held pending and are not granted mid-cycle.
- Reset mid-transfer: all outputs go to their reset values immediately (async). The slave sees cyc drop, and no ack/err is delivered.
- Single master requesting repeatedly: it is re-granted after each one-idle-cycle gap.

Test Plan:
- Single master write: m0 cyc/stb/we, adr=0x10, dat=0xA5 at cycle 0 -> grant_o=01 at cycle 1, s_adr_o=0x10, s_dat_o=0xA5. Slave ack at cycle 2 gives m_ack_o=01. m0 drops cyc -> IDLE next cycle, grant_o=00.
- Contention: m0 and m1 assert cyc at the same edge after reset (pointer 0) -> m0 granted first. After m0 releases, one idle cycle, then m1 granted. Both re-request -> m0 granted next (pointer=0 after m1).
- Block hold: m1 granted, performs 4 stb/ack beats while m0 requests -> grant_o stays 10 for all 4 acks. m0 is granted only after m1 drops cyc.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> m_err_o[g] high exactly on the 4th stalled cycle, s_stb_o low that cycle, no m_ack_o. After master drops cyc, the other master gets the bus.
- Ack vs timeout collision: slave acks on exactly the TIMEOUT_CYCLES-th stalled cycle -> m_ack_o pulses, m_err_o stays 0.
- Async reset mid-transfer: rst_i low between edges while BUSY -> s_cyc_o, grant_o, and m_ack_o go 0 before the next edge. After release, pointer=0 and m0 wins the first contention.
